alarm_clock_fsm: RTL and testbench
==================================

// Module: alarm_clock_fsm
// PURPOSE
//  Main controller of the alarm clock, directly upstream of lcd_driver_4 and the key/alarm/time registers.
//  Consumes keypad codes, alarm/time buttons and the 1 Hz tick.
//  Drives display-select strobes (show_a, show_current_time, show_new_time) into the LCD driver.
//  Drives load strobes (shift, load_new_a, load_new_c, reset_count) into the key register, alarm register and time counter.
// PARAMETERS
//  TIMEOUT_SEC  10     one_second ticks of key inactivity before entry is abandoned (>=1)
//  NOKEY_VAL    4'd10  key code meaning "no key pressed"; codes 0-9 are digits
// PORTS
//  clock              in   1  system clock; all logic on rising edge
//  reset              in   1  synchronous, active-high reset
//  one_second         in   1  1-cycle tick, once per second
//  key                in   4  keypad code; NOKEY_VAL when idle
//  alarm_button       in   1  level, high while alarm button held
//  time_button        in   1  level, high while time button held
//  show_current_time  out  1  LCD shows current time
//  show_a             out  1  LCD shows alarm time
//  show_new_time      out  1  LCD shows key-register digits
//  shift              out  1  1-cycle strobe: key register shifts in key
//  load_new_a         out  1  1-cycle strobe: alarm register loads key digits
//  load_new_c         out  1  1-cycle strobe: time counter loads key digits
//  reset_count        out  1  1-cycle strobe, coincident with load_new_c
// BEHAVIOUR
//  - One clock, synchronous active-high reset.
//  - Moore FSM. Outputs decode combinationally from the registered state; no input-to-output paths.
//  - Reset: state=SHOW_TIME, tcnt=0, show_current_time=1, all other outputs 0.
//    Reset mid-entry abandons the entry; no load strobe is issued.
//  - States and transitions (priority top-down):
//    SHOW_TIME : alarm_button->SHOW_ALARM; key!=NOKEY->KEY_STORED; else stay
//    SHOW_ALARM: show_a=1; !alarm_button->SHOW_TIME
//    KEY_STORED: shift=1, show_new_time=1; ->KEY_WAITED unconditionally (1 cycle); clears tcnt
//    KEY_WAITED: show_new_time=1; key==NOKEY->KEY_ENTRY; timeout->SHOW_TIME; else stay
//    KEY_ENTRY : show_new_time=1; alarm_button->SET_ALARM_TIME; time_button->SET_CURRENT_TIME;
//                key!=NOKEY->KEY_STORED; timeout->SHOW_TIME; else stay
//    SET_ALARM_TIME  : load_new_a=1; ->SHOW_TIME (1 cycle)
//    SET_CURRENT_TIME: load_new_c=1, reset_count=1; ->SHOW_TIME (1 cycle)
//  - show_current_time=1 only in SHOW_TIME. show_a and show_new_time are never both high.
//  - Timeout counter tcnt:
//    - Width $clog2(TIMEOUT_SEC+1).
//    - Increments on one_second while in KEY_WAITED or KEY_ENTRY; saturates at TIMEOUT_SEC.
//    - Cleared in every other state.
//    - timeout = (tcnt==TIMEOUT_SEC).
//  - Simultaneous events:
//    - Both buttons in KEY_ENTRY: alarm wins.
//    - Key and timeout in the same cycle: key wins.
//    - alarm_button and key in SHOW_TIME: alarm wins.
//  - A held key produces exactly one shift; a new shift requires release (KEY_WAITED).
//  - Illegal state encodings recover to SHOW_TIME on the next clock.
// CONFIGURATION
//  KEY_CANCEL_EN defined:
//    - Key code 4'd11 in KEY_WAITED or KEY_ENTRY -> SHOW_TIME next cycle.
//    - No shift and no load strobe are issued.
//    - Code 11 takes priority over buttons and timeout.
//    - Code 11 in SHOW_TIME is ignored (no KEY_STORED).
//  KEY_CANCEL_EN undefined:
//    - Code 11 is treated as an ordinary non-NOKEY key: shifted in like a digit.
// TESTING
//  1. reset=1 for 2 clocks, key=10 -> show_current_time=1, all strobes 0, for >=20 cycles.
//  2. key 2,1,3,4, each held 3 cycles then 10 for 3 cycles; then alarm_button 1 cycle
//     -> exactly 4 shift pulses, then one load_new_a pulse, then show_current_time=1.
//  3. Same digits, then time_button -> load_new_c and reset_count high in the same single cycle.
//  4. One key press, then 10 one_second ticks with no input -> return to SHOW_TIME, no load;
//     press on the 10th tick -> KEY_STORED instead.
//  5. Hold alarm_button 5 cycles from SHOW_TIME -> show_a=1 for those cycles, 0 the cycle after release.
//  6. reset asserted while in KEY_ENTRY with time_button=1 -> no load_new_c; SHOW_TIME next cycle.
//     With KEY_CANCEL_EN: key=11 in KEY_ENTRY -> SHOW_TIME, no strobe.

Source files
------------

// File: rtl/alarm_clock_fsm.sv
// Alarm clock main controller: display select and load strobes for the key, alarm and time registers.
// Optional build macro KEY_CANCEL_EN: key code 11 abandons an entry in progress.
module alarm_clock_fsm #(
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] NOKEY_VAL   = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       show_current_time,
    output logic       show_a,
    output logic       show_new_time,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count
);

    // state            | meaning
    // S_SHOW_TIME      | idle, LCD shows current time
    // S_SHOW_ALARM     | alarm button held, LCD shows alarm time
    // S_KEY_STORED     | one-cycle shift of the pressed key
    // S_KEY_WAITED     | waiting for key release
    // S_KEY_ENTRY      | waiting for next key or a set button
    // S_SET_ALARM_TIME | one-cycle alarm register load
    // S_SET_CUR_TIME   | one-cycle time counter load
    typedef enum logic [2:0] {
        S_SHOW_TIME      = 3'd0,
        S_SHOW_ALARM     = 3'd1,
        S_KEY_STORED     = 3'd2,
        S_KEY_WAITED     = 3'd3,
        S_KEY_ENTRY      = 3'd4,
        S_SET_ALARM_TIME = 3'd5,
        S_SET_CUR_TIME   = 3'd6
    } state_t;

    localparam int TW = $clog2(TIMEOUT_SEC + 1);
    localparam logic [TW-1:0] TC_MAX = TW'(TIMEOUT_SEC);

    state_t          r_state;
    logic [TW-1:0]   r_tcnt;
    logic            w_timeout;
    logic            w_key_valid;
    logic            w_cancel;
    logic            w_key_start;

    assign w_timeout   = (r_tcnt == TC_MAX);
    assign w_key_valid = (key != NOKEY_VAL);
`ifdef KEY_CANCEL_EN
    assign w_cancel    = (key == 4'd11);
`else
    assign w_cancel    = 1'b0;
`endif
    // a cancel code never starts an entry from the idle display
    assign w_key_start = w_key_valid && !w_cancel;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_SHOW_TIME;
            r_tcnt  <= '0;
        end else begin
            if (r_state == S_KEY_WAITED || r_state == S_KEY_ENTRY) begin
                if (one_second && !w_timeout)
                    r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end

            case (r_state)
                S_SHOW_TIME: begin
                    if (alarm_button)     r_state <= S_SHOW_ALARM;
                    else if (w_key_start) r_state <= S_KEY_STORED;
                end
                S_SHOW_ALARM: begin
                    if (!alarm_button) r_state <= S_SHOW_TIME;
                end
                S_KEY_STORED: r_state <= S_KEY_WAITED;
                S_KEY_WAITED: begin
                    if (w_cancel)         r_state <= S_SHOW_TIME;
                    else if (!w_key_valid) r_state <= S_KEY_ENTRY;
                    else if (w_timeout)   r_state <= S_SHOW_TIME;
                end
                S_KEY_ENTRY: begin
                    if (w_cancel)          r_state <= S_SHOW_TIME;
                    else if (alarm_button) r_state <= S_SET_ALARM_TIME;
                    else if (time_button)  r_state <= S_SET_CUR_TIME;
                    else if (w_key_valid)  r_state <= S_KEY_STORED;
                    else if (w_timeout)    r_state <= S_SHOW_TIME;
                end
                S_SET_ALARM_TIME: r_state <= S_SHOW_TIME;
                S_SET_CUR_TIME:   r_state <= S_SHOW_TIME;
                default:          r_state <= S_SHOW_TIME;
            endcase
        end
    end

    assign show_current_time = (r_state == S_SHOW_TIME);
    assign show_a            = (r_state == S_SHOW_ALARM);
    assign show_new_time     = (r_state == S_KEY_STORED) || (r_state == S_KEY_WAITED) ||
                               (r_state == S_KEY_ENTRY);
    assign shift             = (r_state == S_KEY_STORED);
    assign load_new_a        = (r_state == S_SET_ALARM_TIME);
    assign load_new_c        = (r_state == S_SET_CUR_TIME);
    assign reset_count       = (r_state == S_SET_CUR_TIME);

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Bench for alarm_clock_fsm: directed scenarios then random stimulus against a mode-level model.
module tb_alarm_clock_fsm;

    localparam int T = 10;
`ifdef KEY_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic [3:0] key = 4'd10;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       show_current_time, show_a, show_new_time, shift;
    logic       load_new_a, load_new_c, reset_count;

    int errors = 0;
    int checks = 0;
    int n_shift = 0, n_la = 0, n_lc = 0, n_showa = 0;

    // model: mode 0 idle, 1 alarm view, 2 entry; load 0 none, 1 alarm, 2 time
    int m_mode = 0, m_load = 0, m_secs = 0;
    bit m_shift = 0, m_release = 0;

    alarm_clock_fsm #(.TIMEOUT_SEC(T), .NOKEY_VAL(4'd10)) dut (
        .clock(clock), .reset(reset), .one_second(one_second), .key(key),
        .alarm_button(alarm_button), .time_button(time_button),
        .show_current_time(show_current_time), .show_a(show_a),
        .show_new_time(show_new_time), .shift(shift), .load_new_a(load_new_a),
        .load_new_c(load_new_c), .reset_count(reset_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_cancel(input logic [3:0] k);
        return CANCEL && (k == 4'd11);
    endfunction

    task automatic model_step();
        bit timeout;
        if (reset) begin
            m_mode = 0; m_load = 0; m_shift = 0; m_release = 0; m_secs = 0;
        end else if (m_load != 0) begin
            m_load = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (alarm_button) m_mode = 1;
            else if (key != 4'd10 && !is_cancel(key)) begin
                m_mode = 2; m_shift = 1; m_release = 1; m_secs = 0;
            end
        end else if (m_mode == 1) begin
            if (!alarm_button) m_mode = 0;
        end else if (m_shift) begin
            m_shift = 0; m_secs = 0;
        end else begin
            timeout = (m_secs == T);
            if (one_second && m_secs < T) m_secs++;
            if (is_cancel(key)) m_mode = 0;
            else if (m_release) begin
                if (key == 4'd10) m_release = 0;
                else if (timeout) m_mode = 0;
            end
            else if (alarm_button) begin m_load = 1; m_mode = 0; end
            else if (time_button)  begin m_load = 2; m_mode = 0; end
            else if (key != 4'd10) begin m_shift = 1; m_release = 1; end
            else if (timeout) m_mode = 0;
        end
    endtask

    task automatic cyc(input logic rst, input logic sec, input logic [3:0] k,
                       input logic ab, input logic tbn);
        logic [7:0] obs, exp;
        @(negedge clock);
        reset = rst; one_second = sec; key = k; alarm_button = ab; time_button = tbn;
        @(posedge clock);
        model_step();
        #1;
        obs = {1'b0, show_current_time, show_a, show_new_time, shift,
               load_new_a, load_new_c, reset_count};
        exp = {1'b0, m_mode == 0 && m_load == 0, m_mode == 1, m_mode == 2,
               m_mode == 2 && m_shift, m_load == 1, m_load == 2, m_load == 2};
        check("outputs", obs, exp);
        n_shift += int'(shift);
        n_la    += int'(load_new_a);
        n_lc    += int'(load_new_c && reset_count);
        n_showa += int'(show_a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'd10, 0, 0);
    endtask

    task automatic press(input logic [3:0] k);
        for (int i = 0; i < 3; i++) cyc(0, 0, k, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'd10, 0, 0);
    endtask

    task automatic clear_counts();
        n_shift = 0; n_la = 0; n_lc = 0; n_showa = 0;
    endtask

    initial begin
        logic [3:0] rk;
        logic       ra, rt;
        // reset and idle
        cyc(1, 0, 4'd10, 0, 0);
        cyc(1, 0, 4'd10, 0, 0);
        clear_counts();
        idle(20);
        check("idle_strobes", 8'(n_shift + n_la + n_lc), 8'd0);
        check("idle_show_time", {7'd0, show_current_time}, 8'd1);

        // four digits then alarm button
        clear_counts();
        press(4'd2); press(4'd1); press(4'd3); press(4'd4);
        cyc(0, 0, 4'd10, 1, 0);
        idle(3);
        check("alarm_shifts", 8'(n_shift), 8'd4);
        check("alarm_load_a", 8'(n_la), 8'd1);
        check("alarm_load_c", 8'(n_lc), 8'd0);
        check("alarm_back_home", {7'd0, show_current_time}, 8'd1);

        // four digits then time button
        clear_counts();
        press(4'd2); press(4'd1); press(4'd3); press(4'd4);
        cyc(0, 0, 4'd10, 0, 1);
        idle(3);
        check("time_shifts", 8'(n_shift), 8'd4);
        check("time_load_c", 8'(n_lc), 8'd1);
        check("time_load_a", 8'(n_la), 8'd0);

        // timeout abandons entry
        clear_counts();
        press(4'd7);
        for (int i = 0; i < T; i++) begin cyc(0, 1, 4'd10, 0, 0); cyc(0, 0, 4'd10, 0, 0); end
        idle(2);
        check("timeout_home", {7'd0, show_current_time}, 8'd1);
        check("timeout_no_load", 8'(n_la + n_lc), 8'd0);

        // key on the last tick wins over timeout
        clear_counts();
        press(4'd7);
        for (int i = 0; i < T - 1; i++) begin cyc(0, 1, 4'd10, 0, 0); cyc(0, 0, 4'd10, 0, 0); end
        cyc(0, 1, 4'd5, 0, 0);
        cyc(0, 0, 4'd5, 0, 0);
        check("late_key_shifts", 8'(n_shift), 8'd2);
        check("late_key_entry", {7'd0, show_new_time}, 8'd1);
        idle(2);
        for (int i = 0; i < T + 1; i++) cyc(0, 1, 4'd10, 0, 0);
        idle(2);
        check("late_key_home", {7'd0, show_current_time}, 8'd1);

        // alarm display while held
        clear_counts();
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'd10, 1, 0);
        cyc(0, 0, 4'd10, 0, 0);
        check("showa_count", 8'(n_showa), 8'd5);
        cyc(0, 0, 4'd10, 0, 0);
        check("showa_released", {7'd0, show_a}, 8'd0);

        // reset during entry with time button
        clear_counts();
        press(4'd9);
        cyc(1, 0, 4'd10, 0, 1);
        check("reset_entry_home", {7'd0, show_current_time}, 8'd1);
        idle(3);
        check("reset_entry_no_load", 8'(n_lc), 8'd0);

        // code 11 during entry
        clear_counts();
        press(4'd3);
        press(4'd11);
        idle(2);
`ifdef KEY_CANCEL_EN
        check("cancel_shifts", 8'(n_shift), 8'd1);
`else
        check("code11_shifts", 8'(n_shift), 8'd2);
`endif
        for (int i = 0; i < T + 1; i++) cyc(0, 1, 4'd10, 0, 0);
        idle(2);

        // random
        rk = 4'd10; ra = 0; rt = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0)
                rk = ($urandom_range(0, 1) == 0) ? 4'd10 : 4'($urandom_range(0, 11));
            if ($urandom_range(0, 15) == 0) ra = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) rt = ($urandom_range(0, 2) == 0);
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, rk, ra, rt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
